// File: rtl/cpu_step_controller.sv
// ---------------------------------------------------------------------------
// cpu_step_controller
// Run/step control for the Forth core. Produces a one-cycle clock-enable
// (step_en) that advances the CPU in one of four modes: stop, slow auto-step
// (one step per slow_clk rise), manual step (one step per debounced button
// press) and full speed. A CPU halt request parks the controller in HALT until
// the button is pressed with the request released.
//
// Ports
//   clock_in    in   1          system clock, all logic on posedge
//   reset       in   1          synchronous, active-high
//   slow_clk    in   1          divider output, sampled as an async level
//   btn_step    in   1          raw pushbutton, active-high, bouncy
//   sw_mode     in   2          raw switches: 00 STOP 01 SLOW 10 STEP 11 FAST
//   halt_req    in   1          CPU halt request, synchronous level
//   step_en     out  1          1 = CPU executes one step this cycle
//   halted      out  1          1 while in HALT
//   state_out   out  3          FSM state: STOP=0 SLOW=1 STEP=2 FAST=3 HALT=4
//   step_count  out  CNT_WIDTH  wrapping count of step_en cycles
// ---------------------------------------------------------------------------
module cpu_step_controller #(
    parameter logic [27:0] DEBOUNCE_CYCLES = 28'd1000000,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 slow_clk,
    input  logic                 btn_step,
    input  logic [1:0]           sw_mode,
    input  logic                 halt_req,
    output logic                 step_en,
    output logic                 halted,
    output logic [2:0]           state_out,
    output logic [CNT_WIDTH-1:0] step_count
);

    localparam int unsigned DB_W = 28;

    typedef enum logic [2:0] {
        S_STOP = 3'd0,
        S_SLOW = 3'd1,
        S_STEP = 3'd2,
        S_FAST = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   step_en_next;

    logic            slow_s1;
    logic            slow_s2;
    logic            slow_d;
    logic            slow_rise;
    logic            btn_s1;
    logic            btn_s2;
    logic            btn_db;
    logic            btn_db_d;
    logic            btn_press;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      sw_s1;
    logic [1:0]      sw_s2;

    function automatic state_t decode_mode(input logic [1:0] mode);
        case (mode)
            2'b01:   decode_mode = S_SLOW;
            2'b10:   decode_mode = S_STEP;
            2'b11:   decode_mode = S_FAST;
            default: decode_mode = S_STOP;
        endcase
    endfunction

    // Input synchronisers, slow_clk edge detect and button debounce.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            slow_s1   <= 1'b0;
            slow_s2   <= 1'b0;
            slow_d    <= 1'b0;
            slow_rise <= 1'b0;
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_db    <= 1'b0;
            btn_db_d  <= 1'b0;
            btn_press <= 1'b0;
            db_cnt    <= '0;
            sw_s1     <= 2'b00;
            sw_s2     <= 2'b00;
        end else begin
            slow_s1   <= slow_clk;
            slow_s2   <= slow_s1;
            slow_d    <= slow_s2;
            slow_rise <= slow_s2 & ~slow_d;
            btn_s1    <= btn_step;
            btn_s2    <= btn_s1;
            sw_s1     <= sw_mode;
            sw_s2     <= sw_s1;
            // Counter only runs while the synced button disagrees with the
            // accepted value; any agreement (a bounce back) restarts it.
            if (btn_s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DEBOUNCE_CYCLES - 28'd1) begin
                btn_db <= ~btn_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            btn_db_d  <= btn_db;
            btn_press <= btn_db & ~btn_db_d;
        end
    end

    // State register.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= S_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next step enable.
    always_comb begin
        state_next   = decode_mode(sw_s2);
        step_en_next = 1'b0;

        if (halt_req && (state != S_STOP)) begin
            state_next = S_HALT;
        end else if (state == S_HALT) begin
            // Mode switches are ignored until the operator releases the halt.
            state_next = (btn_press && !halt_req) ? decode_mode(sw_s2) : S_HALT;
        end

        case (state)
            S_FAST:  step_en_next = 1'b1;
            S_SLOW:  step_en_next = slow_rise;
            S_STEP:  step_en_next = btn_press;
            default: step_en_next = 1'b0;
        endcase
        if (halt_req) begin
            step_en_next = 1'b0;
        end
    end

    // Registered outputs; halted tracks the state being entered.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            step_en    <= 1'b0;
            halted     <= 1'b0;
            step_count <= '0;
        end else begin
            step_en <= step_en_next;
            halted  <= (state_next == S_HALT);
            if (step_en) begin
                step_count <= step_count + CNT_WIDTH'(1);
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_cpu_step_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_controller
// Directed bench for cpu_step_controller with DEBOUNCE_CYCLES=4, CNT_WIDTH=4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_step_controller;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       slow_clk;
    logic       btn_step;
    logic [1:0] sw_mode;
    logic       halt_req;
    logic       step_en;
    logic       halted;
    logic [2:0] state_out;
    logic [3:0] step_count;

    int checks = 0;
    int errors = 0;

    cpu_step_controller #(
        .DEBOUNCE_CYCLES(28'd4),
        .CNT_WIDTH      (4)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .btn_step  (btn_step),
        .sw_mode   (sw_mode),
        .halt_req  (halt_req),
        .step_en   (step_en),
        .halted    (halted),
        .state_out (state_out),
        .step_count(step_count)
    );

    always #5 clock_in = ~clock_in;

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        int first_k;
        int second_k;
        int third_k;
        int highs;
        bit seen;
        logic [0:26] btn_seq;

        reset    = 1'b1;
        slow_clk = 1'b0;
        btn_step = 1'b0;
        sw_mode  = 2'b00;
        halt_req = 1'b0;
        #1;

        // Reset state.
        do_reset(3);
        check("rst_step_en", 32'(step_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_count", 32'(step_count), 32'd0);

        // FAST: state follows after 3 edges, then continuous steps and wrap.
        sw_mode = 2'b11;
        do_reset(2);
        tick();
        tick();
        check("fast_state_early", 32'(state_out), 32'd0);
        tick();
        check("fast_state", 32'(state_out), 32'd3);
        tick();
        check("fast_step_en0", 32'(step_en), 32'd1);
        check("fast_count0", 32'(step_count), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("fast_step_en", 32'(step_en), 32'd1);
            check("fast_count", 32'(step_count), 32'(i));
        end
        tick();
        check("fast_wrap", 32'(step_count), 32'd0);

        // SLOW: three slow_clk periods of 8 high / 8 low.
        sw_mode = 2'b01;
        do_reset(2);
        for (int i = 0; i < 5; i++) tick();
        check("slow_state", 32'(state_out), 32'd1);
        pulses = 0; first_k = -1; second_k = -1; third_k = -1;
        for (int k = 0; k < 54; k++) begin
            if (k < 48) slow_clk = ((k % 16) < 8);
            else slow_clk = 1'b0;
            tick();
            if (step_en) begin
                pulses++;
                if (pulses == 1) first_k = k;
                else if (pulses == 2) second_k = k;
                else if (pulses == 3) third_k = k;
            end
        end
        check("slow_pulses", 32'(pulses), 32'd3);
        check("slow_latency", 32'(first_k), 32'd3);
        check("slow_gap1", 32'(second_k - first_k), 32'd16);
        check("slow_gap2", 32'(third_k - second_k), 32'd16);
        check("slow_count", 32'(step_count), 32'd3);

        // STEP: bounce, long press, long release gives exactly one step.
        sw_mode = 2'b10;
        do_reset(2);
        for (int i = 0; i < 5; i++) tick();
        check("step_state", 32'(state_out), 32'd2);
        btn_seq = {3'b101, 12'hFFF, 12'h000};
        highs = 0;
        for (int k = 0; k < 27 + 10; k++) begin
            btn_step = (k < 27) ? btn_seq[k] : 1'b0;
            tick();
            if (step_en) highs++;
        end
        check("step_pulses", 32'(highs), 32'd1);
        check("step_count", 32'(step_count), 32'd1);

        // HALT from FAST, mode switches ignored, press resumes.
        sw_mode = 2'b11;
        do_reset(2);
        for (int i = 0; i < 6; i++) tick();
        check("pre_halt_step_en", 32'(step_en), 32'd1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_step_en", 32'(step_en), 32'd0);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_state", 32'(state_out), 32'd4);
        sw_mode = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        sw_mode = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        check("halt_sw_ignored", 32'(state_out), 32'd4);
        check("halt_hold_step_en", 32'(step_en), 32'd0);
        check("halt_hold_halted", 32'(halted), 32'd1);
        sw_mode = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        check("halt_still", 32'(state_out), 32'd4);
        btn_step = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (k == 10) btn_step = 1'b0;
            tick();
            if (state_out == 3'd3) seen = 1'b1;
        end
        btn_step = 1'b0;
        check("resume_seen", 32'(seen), 32'd1);
        check("resume_halted", 32'(halted), 32'd0);
        tick();
        check("resume_step_en", 32'(step_en), 32'd1);
        for (int i = 0; i < 12; i++) tick();

        // Reset while halted.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt2_halted", 32'(halted), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_halt_state", 32'(state_out), 32'd0);
        check("rst_halt_halted", 32'(halted), 32'd0);
        check("rst_halt_count", 32'(step_count), 32'd0);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
